// File: rtl/spike_accumulator_array.sv
// spike_accumulator_array
//   Multi-channel windowed spike counter. Each channel counts spikes over
//   WIN_LEN valid timesteps. At the end of a window, all counts and their
//   saturation/wrap flags are snapshotted into an output register. A
//   valid/ready handshake drains that register.
//
// Ports
//   clk           rising-edge clock
//   rstn          synchronous reset, active-high (name kept for consistency)
//   spike_valid   spike vector valid for this timestep
//   spike         one spike bit per channel
//   clear         synchronous restart of the current window
//   out_valid     snapshot available
//   out_ready     consumer accepts the snapshot
//   out_counts    channel c count at [c*CNT_W +: CNT_W]
//   out_sat       channel c saturated (SATURATE=1) or wrapped (SATURATE=0)
//   out_window_id sequence number of the snapshot
//   step          current timestep index within the window
//   overrun       sticky: a snapshot was discarded
module spike_accumulator_array #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WIN_LEN  = 256,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned ID_W     = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        spike_valid,
  input  logic [NUM_CH-1:0]           spike,
  input  logic                        clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*CNT_W-1:0]     out_counts,
  output logic [NUM_CH-1:0]           out_sat,
  output logic [ID_W-1:0]             out_window_id,
  output logic [$clog2(WIN_LEN)-1:0]  step,
  output logic                        overrun
);

  localparam int unsigned STEP_W = $clog2(WIN_LEN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIN_LEN - 1);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } out_state_t;

  logic [CNT_W-1:0]        acc      [NUM_CH];
  logic [CNT_W-1:0]        acc_next [NUM_CH];
  logic [CNT_W:0]          sum      [NUM_CH];
  logic [NUM_CH-1:0]       sat;
  logic [NUM_CH-1:0]       sat_next;
  logic [NUM_CH*CNT_W-1:0] snap_counts;
  logic [ID_W-1:0]         win_id;
  logic                    win_end;
  logic                    load;
  logic                    drop;
  out_state_t              state;
  out_state_t              state_next;

  // Per-channel next value. The extra sum bit flags overflow, which either
  // clamps or wraps the counter and always marks the channel.
  always_comb begin
    snap_counts = '0;
    sat_next    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum[c] = {1'b0, acc[c]} + {{CNT_W{1'b0}}, spike[c]};
      if (SATURATE != 0 && sum[c][CNT_W]) begin
        acc_next[c] = '1;
      end else begin
        acc_next[c] = sum[c][CNT_W-1:0];
      end
      sat_next[c] = sat[c] | sum[c][CNT_W];
      snap_counts[c*CNT_W +: CNT_W] = acc_next[c];
    end
  end

  // clear outranks a window-end step: no snapshot is produced in that case.
  assign win_end = spike_valid && !clear && (step == LAST_STEP);

  // Accumulator, step and window counter
  always_ff @(posedge clk) begin
    if (rstn) begin
      acc    <= '{default: '0};
      sat    <= '0;
      step   <= '0;
      win_id <= '0;
    end else if (clear) begin
      acc  <= '{default: '0};
      sat  <= '0;
      step <= '0;
    end else if (spike_valid) begin
      if (win_end) begin
        acc    <= '{default: '0};
        sat    <= '0;
        step   <= '0;
        win_id <= win_id + 1'b1;
      end else begin
        acc  <= acc_next;
        sat  <= sat_next;
        step <= step + 1'b1;
      end
    end
  end

  // Output register FSM: state register
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output register FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: if (win_end)   state_next = ST_FULL;
      ST_FULL:  if (out_ready) state_next = win_end ? ST_FULL : ST_EMPTY;
      default:                 state_next = ST_EMPTY;
    endcase
  end

  // Output register FSM: outputs and load/drop decisions
  always_comb begin
    out_valid = (state == ST_FULL);
    load      = win_end && ((state == ST_EMPTY) || out_ready);
    drop      = win_end && (state == ST_FULL) && !out_ready;
  end

  // Snapshot data
  always_ff @(posedge clk) begin
    if (rstn) begin
      out_counts    <= '0;
      out_sat       <= '0;
      out_window_id <= '0;
    end else if (load) begin
      out_counts    <= snap_counts;
      out_sat       <= sat_next;
      out_window_id <= win_id;
    end
  end

  // Sticky overrun flag
  always_ff @(posedge clk) begin
    if (rstn) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_accumulator_array.sv
module tb_spike_accumulator_array;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spike_valid = 1'b0;
  logic [3:0]  spike = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        out_valid;
  logic [15:0] out_counts;
  logic [3:0]  out_sat;
  logic [7:0]  out_window_id;
  logic [2:0]  step;
  logic        overrun;

  logic        s_valid, w_valid;
  logic [15:0] s_counts, w_counts;
  logic [3:0]  s_sat, w_sat;
  logic [7:0]  s_id, w_id;
  logic [4:0]  s_step, w_step;
  logic        s_ovr, w_ovr;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  spike_accumulator_array #(
    .NUM_CH(4), .CNT_W(4), .WIN_LEN(8), .SATURATE(1), .ID_W(8)
  ) dut (
    .clk(clk), .rstn(rstn), .spike_valid(spike_valid), .spike(spike),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_counts(out_counts), .out_sat(out_sat), .out_window_id(out_window_id),
    .step(step), .overrun(overrun)
  );

  spike_accumulator_array #(
    .NUM_CH(4), .CNT_W(4), .WIN_LEN(20), .SATURATE(1), .ID_W(8)
  ) dut_sat (
    .clk(clk), .rstn(rstn), .spike_valid(spike_valid), .spike(spike),
    .clear(clear), .out_valid(s_valid), .out_ready(out_ready),
    .out_counts(s_counts), .out_sat(s_sat), .out_window_id(s_id),
    .step(s_step), .overrun(s_ovr)
  );

  spike_accumulator_array #(
    .NUM_CH(4), .CNT_W(4), .WIN_LEN(20), .SATURATE(0), .ID_W(8)
  ) dut_wrap (
    .clk(clk), .rstn(rstn), .spike_valid(spike_valid), .spike(spike),
    .clear(clear), .out_valid(w_valid), .out_ready(out_ready),
    .out_counts(w_counts), .out_sat(w_sat), .out_window_id(w_id),
    .step(w_step), .overrun(w_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vstep(input logic [3:0] s);
    spike_valid = 1'b1;
    spike       = s;
    tick();
    spike_valid = 1'b0;
    spike       = '0;
  endtask

  task automatic do_reset();
    rstn  = 1'b1;
    clear = 1'b1;
    tick();
    rstn  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] v;

    // Reset state (clear asserted together with rstn)
    do_reset();
    check("rst_valid",   out_valid,     0);
    check("rst_counts",  out_counts,    0);
    check("rst_sat",     out_sat,       0);
    check("rst_id",      out_window_id, 0);
    check("rst_step",    step,          0);
    check("rst_overrun", overrun,       0);

    // Width rules: WIN_LEN=20, ch0 every step
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) vstep(4'b0001);
    check("sat_valid",  s_valid,       1);
    check("sat_count",  s_counts[3:0], 15);
    check("sat_flag",   s_sat,         4'b0001);
    check("wrap_valid", w_valid,       1);
    check("wrap_count", w_counts[3:0], 4);
    check("wrap_flag",  w_sat,         4'b0001);

    // Basic window with mixed spike patterns
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = {(i == 0) ? 1'b1 : 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1};
      vstep(v);
      if (i == 3) begin
        check("step_after4", step, 4);
        tick();
        check("step_idle", step, 4);
      end
      if (i == 6) begin
        check("step_after7",  step,      7);
        check("valid_before", out_valid, 0);
      end
    end
    check("t1_valid",  out_valid,     1);
    check("t1_counts", out_counts,    16'h1408);
    check("t1_sat",    out_sat,       0);
    check("t1_id",     out_window_id, 0);
    check("t1_step",   step,          0);
    tick();
    check("t1_valid_1cyc", out_valid, 0);

    // Back-pressure over two windows
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) vstep(4'b0001);
    check("t3a_valid",  out_valid,  1);
    check("t3a_counts", out_counts, 16'h0008);
    check("t3a_ovr",    overrun,    0);
    for (int i = 0; i < 8; i++) vstep(4'b0010);
    check("t3b_valid",  out_valid,     1);
    check("t3b_counts", out_counts,    16'h0008);
    check("t3b_id",     out_window_id, 0);
    check("t3b_ovr",    overrun,       1);
    out_ready = 1'b1;
    tick();
    check("t3_drain", out_valid, 0);
    for (int i = 0; i < 8; i++) vstep(4'b0100);
    check("t3c_valid",  out_valid,     1);
    check("t3c_counts", out_counts,    16'h0800);
    check("t3c_id",     out_window_id, 2);
    check("t3c_ovr",    overrun,       1);

    // clear drops overrun but keeps the pending snapshot
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ovr",   overrun,       0);
    check("clr_valid", out_valid,     1);
    check("clr_id",    out_window_id, 2);

    // Accept on the exact cycle a new snapshot lands
    for (int i = 0; i < 7; i++) vstep(4'b1000);
    out_ready = 1'b1;
    vstep(4'b1000);
    check("t4_valid",  out_valid,     1);
    check("t4_counts", out_counts,    16'h8000);
    check("t4_id",     out_window_id, 3);
    check("t4_ovr",    overrun,       0);
    tick();
    check("t4_drain", out_valid, 0);

    // clear at step 3 with gaps in spike_valid
    for (int i = 0; i < 3; i++) vstep(4'b0001);
    check("t5_pre_step", step, 3);
    clear = 1'b1;
    vstep(4'b0001);
    clear = 1'b0;
    check("t5_clr_step", step, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (i % 4) tick();
      vstep(4'b0001);
    end
    check("t5_valid",  out_valid,     1);
    check("t5_counts", out_counts,    16'h0008);
    check("t5_id",     out_window_id, 4);
    tick();

    // clear on a window-end step suppresses the snapshot
    for (int i = 0; i < 7; i++) vstep(4'b0001);
    clear = 1'b1;
    vstep(4'b0001);
    clear = 1'b0;
    check("clrend_valid", out_valid, 0);
    check("clrend_step",  step,      0);
    for (int i = 0; i < 8; i++) vstep(4'b0001);
    check("clrend_next_id", out_window_id, 5);
    tick();

    // Reset mid-window with a pending snapshot
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) vstep(4'b0001);
    check("t6_pend_id", out_window_id, 6);
    for (int i = 0; i < 5; i++) vstep(4'b0001);
    check("t6_step", step, 5);
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    check("t6_valid",  out_valid,     0);
    check("t6_counts", out_counts,    0);
    check("t6_sat",    out_sat,       0);
    check("t6_id",     out_window_id, 0);
    check("t6_step0",  step,          0);
    check("t6_ovr",    overrun,       0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) vstep(4'b0001);
    check("t6_next_valid",  out_valid,     1);
    check("t6_next_id",     out_window_id, 0);
    check("t6_next_counts", out_counts,    16'h0008);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
